twiddle_gen: RTL and testbench

- Parametrised twiddle-factor source for the radix-2^2 SDF FFT pipeline.
- Generates W_N^n = cos(2*pi*n/N) - j*sin(2*pi*n/N) for any power-of-two N, with optional conjugation for IFFT.
- Stores only a quarter-wave cosine ROM and rebuilds the full circle from quadrant symmetry.
- Addresses come from the port or from an internal stepping accumulator; output is a valid-qualified pipeline that replaces fixed per-size tables in each SDF stage.

---
 rtl/twiddle_pkg.sv | 26 ++
 rtl/twiddle_gen_if.sv | 28 ++
 rtl/twiddle_qrom.sv | 39 +++
 rtl/twiddle_gen.sv | 114 +++++++++++
 tb/tb_twiddle_gen.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared constants, quadrant encodings and sizing helpers for the twiddle generator
package twiddle_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Largest magnitude representable symmetrically in Q1.(w-1)
    function automatic int q_one(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Quarter-wave table holds k = 0..N/4 inclusive
    function automatic int quarter_len(input int log_n);
        return (1 << (log_n - 2)) + 1;
    endfunction

    // Name of the cosine table image for an N-point transform
    function automatic string rom_file(input int log_n);
        return $sformatf("twiddle_q%0d.memh", 1 << log_n);
    endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: request/response bundle of the twiddle generator
// master drives in_valid, addr, addr_sel, acc_clr, acc_step, inverse;
// slave returns out_valid, tw_re, tw_im, tw_unity.
interface twiddle_gen_if #(
    parameter int LOG_N    = 6,
    parameter int TW_WIDTH = 16
);
    logic                in_valid;
    logic [LOG_N-1:0]    addr;
    logic                addr_sel;
    logic                acc_clr;
    logic [LOG_N-1:0]    acc_step;
    logic                inverse;
    logic                out_valid;
    logic [TW_WIDTH-1:0] tw_re;
    logic [TW_WIDTH-1:0] tw_im;
    logic                tw_unity;

    modport master (
        output in_valid, addr, addr_sel, acc_clr, acc_step, inverse,
        input  out_valid, tw_re, tw_im, tw_unity
    );

    modport slave (
        input  in_valid, addr, addr_sel, acc_clr, acc_step, inverse,
        output out_valid, tw_re, tw_im, tw_unity
    );
endinterface

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: quarter-wave cosine ROM, N/4+1 unsigned entries, two synchronous read ports
// clock/reset: clock and async active-high reset; en: read enable
// addr_a/data_a: port for k; addr_b/data_b: port for N/4-k
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int LOG_N    = 6,
    parameter int TW_WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [LOG_N-3:0]    addr_a,
    input  logic [LOG_N-2:0]    addr_b,
    output logic [TW_WIDTH-2:0] data_a,
    output logic [TW_WIDTH-2:0] data_b
);
    localparam int  DEPTH = quarter_len(LOG_N);
    localparam real PI    = 3.14159265358979323846;

    logic [TW_WIDTH-2:0] tbl [DEPTH];

    // Contents are elaboration-time constants: c[k] = round(cos(2*pi*k/N) * q_one)
    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        localparam real C = $cos(2.0 * PI * i / real'(1 << LOG_N)) * real'(q_one(TW_WIDTH));
        assign tbl[i] = (TW_WIDTH-1)'($rtoi(C + 0.5));
    end

    // Read registers are reset so an unregistered output path starts at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= tbl[{1'b0, addr_a}];
            data_b <= tbl[addr_b];
        end
    end
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: W_N^n twiddle source rebuilt from a quarter-wave cosine ROM
// clock/reset: clock and async active-high reset
// bus (slave): in_valid/addr/addr_sel/acc_clr/acc_step/inverse request side,
//              out_valid/tw_re/tw_im/tw_unity result side, latency 1+TW_FF
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int LOG_N     = 6,
    parameter int TW_WIDTH  = 16,
    parameter bit TW_FF     = 1'b1,
    parameter bit ZERO_AT_0 = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    twiddle_gen_if.slave bus
);
    localparam int               QW  = LOG_N - 2;
    localparam logic [LOG_N-2:0] QTR = (LOG_N-1)'(1 << QW);

    logic [LOG_N-1:0]           acc;
    logic [LOG_N-1:0]           n;
    logic [QW-1:0]              k;
    logic [TW_WIDTH-2:0]        a_q;
    logic [TW_WIDTH-2:0]        b_q;
    quad_t                      q1;
    logic                       inv1;
    logic                       unity1;
    logic                       v1;
    logic signed [TW_WIDTH-1:0] a;
    logic signed [TW_WIDTH-1:0] b;
    logic signed [TW_WIDTH-1:0] re_m;
    logic signed [TW_WIDTH-1:0] im_m;
    logic signed [TW_WIDTH-1:0] re_s;
    logic signed [TW_WIDTH-1:0] im_s;
    logic                       zero;

    assign n = bus.addr_sel ? acc : bus.addr;
    assign k = n[QW-1:0];

    // A request in the clearing cycle has already seen the old acc through n
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end else if (bus.in_valid && bus.addr_sel) begin
            acc <= acc + bus.acc_step;
        end
    end

    // k = 0 reads c[0] and c[N/4], so the second port spans 1..N/4
    twiddle_qrom #(
        .LOG_N    (LOG_N),
        .TW_WIDTH (TW_WIDTH)
    ) u_qrom (
        .clock  (clock),
        .reset  (reset),
        .en     (bus.in_valid),
        .addr_a (k),
        .addr_b (QTR - {1'b0, k}),
        .data_a (a_q),
        .data_b (b_q)
    );

    // Payload only loads on a request so idle cycles leave outputs untouched
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            q1     <= Q0;
            inv1   <= 1'b0;
            unity1 <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                q1     <= quad_t'(n[LOG_N-1 -: 2]);
                inv1   <= bus.inverse;
                unity1 <= (n == '0);
            end
        end
    end

    always_comb begin
        a    = {1'b0, a_q};
        b    = {1'b0, b_q};
        re_m = q1 == Q0 ? a : q1 == Q1 ? -b : q1 == Q2 ? -a : b;
        im_m = q1 == Q0 ? -b : q1 == Q1 ? -a : q1 == Q2 ? b : a;
        zero = ZERO_AT_0 && unity1;
        re_s = zero ? '0 : re_m;
        im_s = zero ? '0 : (inv1 ? -im_m : im_m);
    end

    if (TW_FF) begin : g_ff
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                bus.out_valid <= 1'b0;
                bus.tw_re     <= '0;
                bus.tw_im     <= '0;
                bus.tw_unity  <= 1'b0;
            end else begin
                bus.out_valid <= v1;
                if (v1) begin
                    bus.tw_re    <= re_s;
                    bus.tw_im    <= im_s;
                    bus.tw_unity <= unity1;
                end
            end
        end
    end else begin : g_comb
        assign bus.out_valid = v1;
        assign bus.tw_re     = re_s;
        assign bus.tw_im     = im_s;
        assign bus.tw_unity  = unity1;
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed checks of twiddle_gen for N = 8, 64 and 1024
module tb_twiddle_gen;
    localparam real PI = 3.14159265358979323846;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    twiddle_gen_if #(.LOG_N(6),  .TW_WIDTH(16)) b6 ();
    twiddle_gen_if #(.LOG_N(3),  .TW_WIDTH(16)) b3 ();
    twiddle_gen_if #(.LOG_N(10), .TW_WIDTH(16)) b10 ();

    twiddle_gen #(.LOG_N(6), .TW_WIDTH(16), .TW_FF(1'b1), .ZERO_AT_0(1'b1))
        u6 (.clock(clock), .reset(reset), .bus(b6));
    twiddle_gen #(.LOG_N(3), .TW_WIDTH(16), .TW_FF(1'b0), .ZERO_AT_0(1'b0))
        u3 (.clock(clock), .reset(reset), .bus(b3));
    twiddle_gen #(.LOG_N(10), .TW_WIDTH(16), .TW_FF(1'b0), .ZERO_AT_0(1'b1))
        u10 (.clock(clock), .reset(reset), .bus(b10));

    function automatic void model(input int n, input int log_n, input bit inv, input bit z,
                                  output int re, output int im);
        real ang;
        ang = 2.0 * PI * real'(n) / real'(1 << log_n);
        re  = int'($cos(ang) * 32767.0);
        im  = -int'($sin(ang) * 32767.0);
        if (inv) im = -im;
        if (z && n == 0) begin
            re = 0;
            im = 0;
        end
    endfunction

    function automatic bit near(input int x, input int y);
        return (x - y) <= 1 && (y - x) <= 1;
    endfunction

    task automatic idle_all();
        b6.in_valid = 0;  b6.addr = '0;  b6.addr_sel = 0;  b6.acc_clr = 0;  b6.acc_step = '0;  b6.inverse = 0;
        b3.in_valid = 0;  b3.addr = '0;  b3.addr_sel = 0;  b3.acc_clr = 0;  b3.acc_step = '0;  b3.inverse = 0;
        b10.in_valid = 0; b10.addr = '0; b10.addr_sel = 0; b10.acc_clr = 0; b10.acc_step = '0; b10.inverse = 0;
    endtask

    task automatic test_reset();
        int seen = 0;
        #12;
        checks++;
        if (b6.out_valid !== 1'b0 || b6.tw_re !== 16'h0 || b6.tw_im !== 16'h0 || b6.tw_unity !== 1'b0) begin
            errors++;
            $display("FAIL reset_n64 got v=%b re=%h im=%h u=%b want 0/0000/0000/0",
                     b6.out_valid, b6.tw_re, b6.tw_im, b6.tw_unity);
        end
        checks++;
        if (b3.out_valid !== 1'b0 || b3.tw_re !== 16'h0 || b3.tw_im !== 16'h0 || b3.tw_unity !== 1'b0) begin
            errors++;
            $display("FAIL reset_n8 got v=%b re=%h im=%h u=%b want 0/0000/0000/0",
                     b3.out_valid, b3.tw_re, b3.tw_im, b3.tw_unity);
        end
        checks++;
        if (b10.out_valid !== 1'b0 || b10.tw_re !== 16'h0 || b10.tw_im !== 16'h0 || b10.tw_unity !== 1'b0) begin
            errors++;
            $display("FAIL reset_n1024 got v=%b re=%h im=%h u=%b want 0/0000/0000/0",
                     b10.out_valid, b10.tw_re, b10.tw_im, b10.tw_unity);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (b6.out_valid || b3.out_valid || b10.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_idle got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_sweep64(input bit inv);
        int iss[64];
        int dn[5]  = '{0, 8, 16, 32, 48};
        int dre[5] = '{0, 23170, 0, -32767, 0};
        int dim[5] = '{0, -23170, -32767, 0, 32767};
        int got = 0;
        int er, ei, ar, ai;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    @(posedge clock); #1;
                    b6.in_valid = 1; b6.addr = 6'(i); b6.inverse = inv; iss[i] = cyc;
                end
                @(posedge clock); #1;
                b6.in_valid = 0;
            end
            begin
                for (int t = 0; t < 200 && got < 64; t++) begin
                    @(negedge clock);
                    if (b6.out_valid) begin
                        ar = int'($signed(b6.tw_re));
                        ai = int'($signed(b6.tw_im));
                        model(got, 6, inv, 1'b1, er, ei);
                        checks++;
                        if (!near(ar, er) || !near(ai, ei) || b6.tw_unity !== (got == 0)) begin
                            errors++;
                            $display("FAIL sweep64 inv=%0d n=%0d got %0d/%0d u=%b want %0d/%0d u=%0d",
                                     inv, got, ar, ai, b6.tw_unity, er, ei, got == 0);
                        end
                        checks++;
                        if (cyc - iss[got] != 2) begin
                            errors++;
                            $display("FAIL latency64 n=%0d got %0d want 2", got, cyc - iss[got]);
                        end
                        for (int d = 0; d < 5; d++) begin
                            if (dn[d] == got) begin
                                checks++;
                                if (ar != dre[d] || ai != (inv ? -dim[d] : dim[d])) begin
                                    errors++;
                                    $display("FAIL exact64 inv=%0d n=%0d got %0d/%0d want %0d/%0d",
                                             inv, got, ar, ai, dre[d], inv ? -dim[d] : dim[d]);
                                end
                            end
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 64) begin
            errors++;
            $display("FAIL timeout64 got %0d results want 64", got);
        end
        repeat (3) @(negedge clock);
        model(63, 6, inv, 1'b1, er, ei);
        checks++;
        if (b6.out_valid !== 1'b0 || int'($signed(b6.tw_re)) != er || int'($signed(b6.tw_im)) != ei) begin
            errors++;
            $display("FAIL hold64 got v=%b %0d/%0d want 0 %0d/%0d",
                     b6.out_valid, $signed(b6.tw_re), $signed(b6.tw_im), er, ei);
        end
    endtask

    task automatic test_sweep8();
        int iss[8];
        int got = 0;
        int er, ei, ar, ai;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clock); #1;
                    b3.in_valid = 1; b3.addr = 3'(i); b3.inverse = 0; iss[i] = cyc;
                end
                @(posedge clock); #1;
                b3.in_valid = 0;
            end
            begin
                for (int t = 0; t < 40 && got < 8; t++) begin
                    @(negedge clock);
                    if (b3.out_valid) begin
                        ar = int'($signed(b3.tw_re));
                        ai = int'($signed(b3.tw_im));
                        model(got, 3, 1'b0, 1'b0, er, ei);
                        checks++;
                        if (!near(ar, er) || !near(ai, ei) || b3.tw_unity !== (got == 0) || cyc - iss[got] != 1) begin
                            errors++;
                            $display("FAIL sweep8 n=%0d got %0d/%0d u=%b lat=%0d want %0d/%0d u=%0d lat=1",
                                     got, ar, ai, b3.tw_unity, cyc - iss[got], er, ei, got == 0);
                        end
                        if (got == 0) begin
                            checks++;
                            if (b3.tw_re !== 16'h7FFF || b3.tw_im !== 16'h0000 || b3.tw_unity !== 1'b1) begin
                                errors++;
                                $display("FAIL unity_no_zero got %h/%h u=%b want 7fff/0000 u=1",
                                         b3.tw_re, b3.tw_im, b3.tw_unity);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL timeout8 got %0d results want 8", got);
        end
    endtask

    task automatic test_sweep1024();
        int iss[1024];
        int got = 0;
        int er, ei, ar, ai;
        fork
            begin
                for (int i = 0; i < 1024; i++) begin
                    @(posedge clock); #1;
                    b10.in_valid = 1; b10.addr = 10'(i); b10.inverse = (i % 3 == 0); iss[i] = cyc;
                end
                @(posedge clock); #1;
                b10.in_valid = 0;
            end
            begin
                for (int t = 0; t < 1100 && got < 1024; t++) begin
                    @(negedge clock);
                    if (b10.out_valid) begin
                        ar = int'($signed(b10.tw_re));
                        ai = int'($signed(b10.tw_im));
                        model(got, 10, got % 3 == 0, 1'b1, er, ei);
                        checks++;
                        if (!near(ar, er) || !near(ai, ei) || b10.tw_unity !== (got == 0) || cyc - iss[got] != 1) begin
                            errors++;
                            $display("FAIL sweep1024 n=%0d got %0d/%0d u=%b lat=%0d want %0d/%0d u=%0d lat=1",
                                     got, ar, ai, b10.tw_unity, cyc - iss[got], er, ei, got == 0);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 1024) begin
            errors++;
            $display("FAIL timeout1024 got %0d results want 1024", got);
        end
    endtask

    task automatic test_accumulator();
        int exp_n[23];
        int iss[23];
        int got = 0;
        int er, ei, ar, ai;
        for (int i = 0; i < 20; i++) exp_n[i] = (5 * i) % 64;
        exp_n[20] = 36;
        exp_n[21] = 0;
        exp_n[22] = 5;
        fork
            begin
                b6.addr_sel = 1; b6.acc_step = 6'd5; b6.addr = 6'd63; b6.inverse = 0;
                for (int i = 0; i < 23; i++) begin
                    @(posedge clock); #1;
                    b6.in_valid = 1; b6.acc_clr = (i == 20); iss[i] = cyc;
                    @(posedge clock); #1;
                    b6.in_valid = 0; b6.acc_clr = 0;
                    if (i % 3 == 0) @(posedge clock);
                end
            end
            begin
                for (int t = 0; t < 120 && got < 23; t++) begin
                    @(negedge clock);
                    if (b6.out_valid) begin
                        ar = int'($signed(b6.tw_re));
                        ai = int'($signed(b6.tw_im));
                        model(exp_n[got], 6, 1'b0, 1'b1, er, ei);
                        checks++;
                        if (!near(ar, er) || !near(ai, ei) || b6.tw_unity !== (exp_n[got] == 0) || cyc - iss[got] != 2) begin
                            errors++;
                            $display("FAIL acc idx=%0d n=%0d got %0d/%0d u=%b lat=%0d want %0d/%0d lat=2",
                                     got, exp_n[got], ar, ai, b6.tw_unity, cyc - iss[got], er, ei);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 23) begin
            errors++;
            $display("FAIL timeout_acc got %0d results want 23", got);
        end
        b6.addr_sel = 0;
    endtask

    task automatic test_async_reset();
        int seen = 0;
        @(posedge clock); #1;
        b6.addr_sel = 0; b6.in_valid = 1; b6.addr = 6'd8;
        @(posedge clock); #1;
        b6.addr = 6'd20;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (b6.out_valid !== 1'b0 || b6.tw_re !== 16'h0 || b6.tw_im !== 16'h0 || b6.tw_unity !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b re=%h im=%h u=%b want 0/0000/0000/0",
                     b6.out_valid, b6.tw_re, b6.tw_im, b6.tw_unity);
        end
        b6.in_valid = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (b6.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_valid got %0d valid cycles want 0", seen);
        end
        @(posedge clock); #1;
        b6.addr_sel = 1; b6.acc_step = 6'd3; b6.in_valid = 1;
        @(posedge clock); #1;
        b6.in_valid = 0; b6.addr_sel = 0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (b6.out_valid !== 1'b1 || b6.tw_re !== 16'h0 || b6.tw_im !== 16'h0 || b6.tw_unity !== 1'b1) begin
            errors++;
            $display("FAIL acc_after_reset got v=%b re=%h im=%h u=%b want 1/0000/0000/1",
                     b6.out_valid, b6.tw_re, b6.tw_im, b6.tw_unity);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_sweep64(1'b0);
        test_sweep64(1'b1);
        test_sweep8();
        test_sweep1024();
        test_accumulator();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
